snn_layer_tm: RTL and testbench
===============================

Name: snn_layer_tm

Overview:
Time-multiplexed two-layer leaky integrate-and-fire network, parametrised in neuron count and widths. N_IN hidden LIF neurons share one update datapath and keep their membranes in a register array; per-neuron refractory counters are supported. Hidden spikes are weighted by run-time-programmable signed weights and summed into one output LIF neuron. Each timestep is started with a valid/ready handshake and completed with an out_valid pulse.

Parameters:
N_IN, 8, number of hidden neurons (>=2)
CUR_W, 4, unsigned input current width per neuron
STATE_W, 8, unsigned membrane width (hidden and output)
W_W, 4, signed weight width
BETA_SHIFT, 3, hidden leak: v - (v>>BETA_SHIFT), i.e. beta = 0.875
THRESH, 64, hidden firing threshold
REFRAC, 1, refractory timesteps after a hidden spike (0 = none)
OUT_BETA_SHIFT, 0, output leak shift; 0 = no leak (beta = 1)
OUT_THRESH, 4, output firing threshold

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
current  in  N_IN*CUR_W  per-neuron currents; neuron i uses [i*CUR_W +: CUR_W]; sampled on acceptance
step_valid  in  1  request one timestep
step_ready  out  1  high only in IDLE
cfg_we  in  1  weight write strobe
cfg_addr  in  clog2(N_IN)  weight index
cfg_wdata  in  W_W  signed weight
clear_state  in  1  zero all membranes and refractory counters (IDLE only)
spike_vec  out  N_IN  hidden spikes of the last completed step
out_spike  out  1  output neuron spike of the last completed step
out_state  out  STATE_W  output membrane after the last step
out_valid  out  1  one-cycle pulse when the step completes

Behaviour:
- Clock is clk. Reset is rst_n: synchronous, active-low.
- Reset: FSM to IDLE; all membranes, refractory counters, spike_vec, out_spike, out_state, out_valid = 0; every weight = +1. Reset mid-step aborts the step; out_valid is not pulsed.
- FSM states:
  - IDLE: step_ready=1. On step_valid at edge E0: latch current, clear accumulator and index, go to UPDATE.
  - UPDATE: neuron idx is updated at edge E0+1+idx. After idx=N_IN-1, go to OUTPUT.
  - OUTPUT: at edge E0+N_IN+1, update the output neuron, set out_valid=1, go to IDLE.
- Latency and throughput: out_valid rises N_IN+1 cycles after acceptance. The next step can be accepted at edge E0+N_IN+2.
- Hidden neuron update:
  - If refrac>0: I treated as 0, refrac decrements, no spike.
  - Otherwise: v' = v - (v>>BETA_SHIFT) + I, computed STATE_W+1 wide and saturated at 2^STATE_W-1.
  - If v' >= THRESH: spike=1, v = v' - THRESH (reset by subtraction), refrac = REFRAC. Else v = v'.
  - spike_vec[idx] is written in its update cycle. All bits are valid together with out_valid.
- Accumulator: signed, W_W+clog2(N_IN)+1 bits. On each hidden spike, add weight[idx].
- Output neuron:
  - u' = leak(u) + acc, where leak(u) = u if OUT_BETA_SHIFT=0, else u - (u>>OUT_BETA_SHIFT).
  - u' is clamped to [0, 2^STATE_W-1].
  - If u' >= OUT_THRESH: out_spike=1, u = u' - OUT_THRESH. Else out_spike=0, u = u'.
  - out_state = u.
- cfg_we: takes effect at the next edge only in IDLE; writes in other states are dropped. A write to the same address on the acceptance edge lands before the step.
- clear_state in IDLE: zero membranes, refrac counters and out_state; weights keep their values. Ignored outside IDLE. If clear_state and step_valid are both high, clear applies and the step is accepted with zeroed state.
- Current changes after acceptance have no effect on the running step.

Test Plan:
1. Reset for 2 cycles, release -> all outputs 0, step_ready=1, weights read back as +1 via behaviour (test 4).
2. Neuron 0 current=15, others 0, 7 steps -> v0 = 15, 29, 41, 51, 60, then spike at step 6 with v0=4; step 7 refractory: no spike, v0=4.
3. Accept at edge 0 -> step_ready low cycles 1..9, out_valid high only after edge 9, new step accepted at edge 10.
4. Drive all 8 neurons to spike in the same step with weights +1 -> acc=8, out_spike=1, out_state=4. Rerun from clear_state with all weights -1 -> out_state clamps to 0, out_spike=0.
5. cfg_we to address 3 with value -2 during UPDATE -> dropped; same write in IDLE -> weight 3 = -2 on the next step.
6. rst_n low at edge E0+4 -> following cycle IDLE, all state 0, no out_valid pulse, weights +1.

Source files
------------

// File: rtl/snn_layer_tm.sv
// snn_layer_tm: time-multiplexed two-layer LIF network. N_IN hidden neurons
// share one datapath and feed one weighted-sum output LIF neuron.
// Ports: clk, rst_n (sync, active-low); current/step_valid/step_ready start
// a timestep; cfg_we/cfg_addr/cfg_wdata program weights in IDLE;
// clear_state zeroes membranes in IDLE; spike_vec/out_spike/out_state are
// the results, qualified by the one-cycle out_valid pulse.
module snn_layer_tm #(
    parameter int N_IN           = 8,
    parameter int CUR_W          = 4,
    parameter int STATE_W        = 8,
    parameter int W_W            = 4,
    parameter int BETA_SHIFT     = 3,
    parameter int THRESH         = 64,
    parameter int REFRAC         = 1,
    parameter int OUT_BETA_SHIFT = 0,
    parameter int OUT_THRESH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_IN*CUR_W-1:0]     current,
    input  logic                      step_valid,
    output logic                      step_ready,
    input  logic                      cfg_we,
    input  logic [$clog2(N_IN)-1:0]   cfg_addr,
    input  logic [W_W-1:0]            cfg_wdata,
    input  logic                      clear_state,
    output logic [N_IN-1:0]           spike_vec,
    output logic                      out_spike,
    output logic [STATE_W-1:0]        out_state,
    output logic                      out_valid
);
    localparam int IDX_W = $clog2(N_IN);
    localparam int ACC_W = W_W + IDX_W + 1;
    localparam int RF_W  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int OW    = STATE_W + ACC_W + 2;

    typedef enum logic [1:0] {IDLE, UPDATE, OUTPUT} state_t;

    state_t state_q, state_d;

    logic [N_IN*CUR_W-1:0] cur_q;
    logic [STATE_W-1:0]    v_q  [N_IN];
    logic [RF_W-1:0]       rf_q [N_IN];
    logic [W_W-1:0]        w_q  [N_IN];
    logic [IDX_W-1:0]      idx_q;
    logic signed [ACC_W-1:0] acc_q;

    // Hidden neuron datapath for the neuron selected by idx_q
    logic [STATE_W-1:0] v_cur, v_leak, v_sat, v_next;
    logic [CUR_W-1:0]   i_cur;
    logic [STATE_W:0]   v_sum;
    logic [RF_W-1:0]    rf_cur, rf_next;
    logic               in_refrac, fire;
    logic signed [ACC_W-1:0] w_ext;

    always_comb begin
        v_cur     = v_q[idx_q];
        rf_cur    = rf_q[idx_q];
        i_cur     = cur_q[idx_q*CUR_W +: CUR_W];
        in_refrac = (rf_cur != '0);
        v_leak    = v_cur - (v_cur >> BETA_SHIFT);
        v_sum     = {1'b0, v_leak};
        if (!in_refrac)
            v_sum = v_sum + (STATE_W+1)'(i_cur);
        v_sat  = v_sum[STATE_W] ? '1 : v_sum[STATE_W-1:0];
        fire   = !in_refrac && (v_sat >= STATE_W'(THRESH));
        v_next = fire ? v_sat - STATE_W'(THRESH) : v_sat;
        if (in_refrac)
            rf_next = rf_cur - RF_W'(1);
        else if (fire)
            rf_next = RF_W'(REFRAC);
        else
            rf_next = '0;
        w_ext = $signed({{(ACC_W-W_W){w_q[idx_q][W_W-1]}}, w_q[idx_q]});
    end

    // Output neuron datapath; the sum is wide enough to never wrap
    logic [STATE_W-1:0]     u_leak, u_clamp, u_next;
    logic signed [OW-1:0]   u_sum, u_max;
    logic                   o_fire;

    always_comb begin
        if (OUT_BETA_SHIFT == 0)
            u_leak = out_state;
        else
            u_leak = out_state - (out_state >> OUT_BETA_SHIFT);
        u_max = $signed({{(OW-STATE_W){1'b0}}, {STATE_W{1'b1}}});
        u_sum = $signed({{(OW-STATE_W){1'b0}}, u_leak})
              + $signed({{(OW-ACC_W){acc_q[ACC_W-1]}}, acc_q});
        if (u_sum < 0)
            u_clamp = '0;
        else if (u_sum > u_max)
            u_clamp = '1;
        else
            u_clamp = u_sum[STATE_W-1:0];
        o_fire = (u_clamp >= STATE_W'(OUT_THRESH));
        u_next = o_fire ? u_clamp - STATE_W'(OUT_THRESH) : u_clamp;
    end

    assign step_ready = (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (step_valid) state_d = UPDATE;
            UPDATE:  if (idx_q == IDX_W'(N_IN - 1)) state_d = OUTPUT;
            OUTPUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_q     <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            spike_vec <= '0;
            out_spike <= 1'b0;
            out_state <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                v_q[i]  <= '0;
                rf_q[i] <= '0;
                w_q[i]  <= W_W'(1);
            end
        end else begin
            out_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cfg_we)
                        w_q[cfg_addr] <= cfg_wdata;
                    if (clear_state) begin
                        out_state <= '0;
                        for (int i = 0; i < N_IN; i++) begin
                            v_q[i]  <= '0;
                            rf_q[i] <= '0;
                        end
                    end
                    if (step_valid) begin
                        cur_q <= current;
                        idx_q <= '0;
                        acc_q <= '0;
                    end
                end
                UPDATE: begin
                    v_q[idx_q]       <= v_next;
                    rf_q[idx_q]      <= rf_next;
                    spike_vec[idx_q] <= fire;
                    if (fire)
                        acc_q <= acc_q + w_ext;
                    idx_q <= idx_q + IDX_W'(1);
                end
                OUTPUT: begin
                    out_state <= u_next;
                    out_spike <= o_fire;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_snn_layer_tm.sv
// tb_snn_layer_tm: table-driven timestep vectors with a result scoreboard.
// Expected outputs are hand-derived per step for the default parameters.
module tb_snn_layer_tm;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] current;
    logic        step_valid;
    logic        step_ready;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [3:0]  cfg_wdata;
    logic        clear_state;
    logic [7:0]  spike_vec;
    logic        out_spike;
    logic [7:0]  out_state;
    logic        out_valid;

    snn_layer_tm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .current     (current),
        .step_valid  (step_valid),
        .step_ready  (step_ready),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .clear_state (clear_state),
        .spike_vec   (spike_vec),
        .out_spike   (out_spike),
        .out_state   (out_state),
        .out_valid   (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  wmask;
        logic [3:0]  wdata;
        logic        clr;
        logic [31:0] cur;
        logic        mid;
        logic [7:0]  sv;
        logic        os;
        logic [7:0]  st;
    } vec_t;

    typedef struct {
        logic [7:0] sv;
        logic       os;
        logic [7:0] st;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   t_done = 0;
    bit   b2b    = 0;

    localparam logic [31:0] ALL = 32'hFFFF_FFFF;
    localparam logic [31:0] N0  = 32'h0000_000F;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] wm, input logic [3:0] wd,
                                input logic c, input logic [31:0] cu,
                                input logic m, input logic [7:0] sv,
                                input logic os, input logic [7:0] st);
        vec_t v;
        v.wmask = wm; v.wdata = wd; v.clr = c; v.cur = cu; v.mid = m;
        v.sv = sv; v.os = os; v.st = st;
        return v;
    endfunction

    // Scoreboard: each completed step pops one expected record
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("spike_vec", 32'(spike_vec), 32'(e.sv));
                chk("out_spike", 32'(out_spike), 32'(e.os));
                chk("out_state", 32'(out_state), 32'(e.st));
            end
        end
    end

    task automatic do_step(input vec_t e);
        exp_t x;
        int   t0;
        int   guard;
        bit   ready_bad;
        if (e.wmask != 0) begin
            for (int a = 0; a < 8; a++) begin
                if (e.wmask[a]) begin
                    @(negedge clk);
                    cfg_we    = 1'b1;
                    cfg_addr  = 3'(a);
                    cfg_wdata = e.wdata;
                end
            end
            @(negedge clk);
            cfg_we = 1'b0;
            b2b    = 0;
        end
        x.sv = e.sv; x.os = e.os; x.st = e.st;
        sb.push_back(x);
        step_valid  = 1'b1;
        clear_state = e.clr;
        current     = e.cur;
        @(posedge clk);
        #1;
        step_valid  = 1'b0;
        clear_state = 1'b0;
        current     = ~e.cur;
        t0 = cyc;
        chk("accepted", 32'(step_ready), 32'd0);
        if (b2b)
            chk("back_to_back", 32'(t0 - t_done), 32'd1);
        if (e.mid) begin
            @(negedge clk);
            cfg_we    = 1'b1;
            cfg_addr  = 3'd3;
            cfg_wdata = 4'hE;
            @(negedge clk);
            cfg_we = 1'b0;
        end
        guard     = 0;
        ready_bad = 0;
        while (out_valid !== 1'b1 && guard < 40) begin
            if (step_ready !== 1'b0) ready_bad = 1;
            @(posedge clk);
            #1;
            guard++;
        end
        chk("ready_low", 32'(ready_bad), 32'd0);
        chk("latency", 32'(cyc - t0), 32'd9);
        chk("ready_done", 32'(step_ready), 32'd1);
        t_done = cyc;
        b2b    = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; current = '0; step_valid = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_wdata = '0; clear_state = 1'b0;

        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(8'h00, 4'h0, 0, N0, 0, 8'h00, 0, 8'd0));
        tbl.push_back(mk(8'h00, 4'h0, 0, N0, 0, 8'h01, 0, 8'd1));
        tbl.push_back(mk(8'h00, 4'h0, 0, N0, 0, 8'h00, 0, 8'd1));
        tbl.push_back(mk(8'h00, 4'h0, 0, '0, 0, 8'h00, 0, 8'd1));
        tbl.push_back(mk(8'h00, 4'h0, 1, ALL, 0, 8'h00, 0, 8'd0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(8'h00, 4'h0, 0, ALL, 0, 8'h00, 0, 8'd0));
        tbl.push_back(mk(8'h00, 4'h0, 0, ALL, 0, 8'hFF, 1, 8'd4));
        tbl.push_back(mk(8'hFF, 4'hF, 1, ALL, 0, 8'h00, 0, 8'd0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(8'h00, 4'h0, 0, ALL, 0, 8'h00, 0, 8'd0));
        tbl.push_back(mk(8'h00, 4'h0, 0, ALL, 0, 8'hFF, 0, 8'd0));
        tbl.push_back(mk(8'hFF, 4'h1, 1, ALL, 1, 8'h00, 0, 8'd0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(8'h00, 4'h0, 0, ALL, 0, 8'h00, 0, 8'd0));
        tbl.push_back(mk(8'h00, 4'h0, 0, ALL, 0, 8'hFF, 1, 8'd4));
        tbl.push_back(mk(8'h08, 4'hE, 1, ALL, 0, 8'h00, 0, 8'd0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(8'h00, 4'h0, 0, ALL, 0, 8'h00, 0, 8'd0));
        tbl.push_back(mk(8'h00, 4'h0, 0, ALL, 0, 8'hFF, 1, 8'd1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(8'h00, 4'h0, 0, ALL, 0, 8'h00, 0, 8'd0));
        tbl.push_back(mk(8'h00, 4'h0, 0, ALL, 0, 8'hFF, 1, 8'd4));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_spike_vec", 32'(spike_vec), 32'd0);
        chk("rst_out_spike", 32'(out_spike), 32'd0);
        chk("rst_out_state", 32'(out_state), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(step_ready), 32'd1);

        for (int i = 0; i < 32; i++)
            do_step(tbl[i]);

        // Reset in the middle of a step: aborted, no completion pulse
        step_valid = 1'b1;
        current    = ALL;
        @(posedge clk);
        #1;
        step_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_ready", 32'(step_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out_state", 32'(out_state), 32'd0);
        chk("abort_spike_vec", 32'(spike_vec), 32'd0);
        chk("abort_out_spike", 32'(out_spike), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("abort_idle", 32'(step_ready), 32'd1);
        b2b = 0;

        for (int i = 32; i < tbl.size(); i++)
            do_step(tbl[i]);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
